uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serial transmit side of the UART link: accepts a parallel byte with a valid strobe and shifts out one asynchronous frame on a single line, LSB first. The frame is a start bit, DATA_WIDTH data bits, an optional parity bit and one stop bit. Parity mode and type follow the same convention as the receive path (0 = even, 1 = odd), so this block's output loops back directly into the UART RX chain for link testing. Bit timing comes from an internal prescale counter; no external baud tick is needed.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE, 8, CLK cycles per serial bit; must be ≥ 2
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset; one clock, reset is synchronous and active-high
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled on accept
- Data_Valid  input  1  request to send P_DATA; honoured only when idle
- PAR_EN  input  1  1 = insert parity bit; sampled on accept
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept
- TX_OUT  output  1  serial line; idles high
- Busy  output  1  high while a frame is in flight

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE
  - TX_OUT = 1, Busy = 0.
  - When Data_Valid = 1, latch P_DATA, PAR_EN and PAR_TYP into the shift/config registers.
  - Compute the parity bit from the latched data: even = ^data, odd = ~^data.
  - Go to START.
- START: drive TX_OUT = 0 for PRESCALE cycles, then go to DATA.
- DATA
  - Drive shift_reg[0] for PRESCALE cycles per bit, then shift right.
  - A bit counter runs 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if latched PAR_EN = 1, otherwise go to STOP.
- PARITY: drive the latched parity bit for PRESCALE cycles, then go to STOP.
- STOP: drive TX_OUT = 1 for PRESCALE cycles, then go to IDLE.
- Prescale counter: 0..PRESCALE-1, width $clog2(PRESCALE). It resets to 0 on every state change and wraps at PRESCALE-1, which is the bit-end strobe.
- Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored outside IDLE. A change mid-frame does not alter the frame in flight.
- Busy = 1 in every state except IDLE.
- Reset values: state IDLE, TX_OUT = 1, Busy = 0, all counters 0, shift register 0, parity register 0.
- RST during a frame aborts it. The following edge shows TX_OUT = 1 and Busy = 0. No partial stop bit is emitted.
- RST takes priority over Data_Valid on the same edge.

## Timing
- Accept edge E: Data_Valid = 1 while in IDLE.
- At E+1: TX_OUT = 0 (start bit) and Busy = 1.
- Start bit covers cycles E+1..E+PRESCALE.
- Data bit k (LSB = 0) covers cycles E+(k+1)·PRESCALE+1 .. E+(k+2)·PRESCALE.
- Frame length F = (DATA_WIDTH + 2 + PAR_EN)·PRESCALE cycles.
- Busy is high for exactly F cycles. It falls at E+F+1, with TX_OUT = 1.
- Back-to-back frames:
  - Data_Valid held high continuously gives a new accept on the first IDLE edge.
  - The next start bit then begins at E+F+2, so there is exactly one idle CLK cycle between stop and start.
- Data_Valid asserted while Busy = 1 is dropped. It is not queued.

## Test plan
- Reset: assert RST for 2 cycles with Data_Valid = 1 and P_DATA = 0xFF → TX_OUT = 1 and Busy = 0 throughout and on the first cycle after release. No frame starts until Data_Valid is sampled after RST = 0.
- No parity: PRESCALE = 8, P_DATA = 0xA5, PAR_EN = 0, one-cycle Data_Valid.
  - Required line sequence in 8-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - Busy is high for exactly 80 cycles.
- Parity: P_DATA = 0x07, PAR_EN = 1, PAR_TYP = 0 → parity bit 1, Busy high for 88 cycles. Repeat with PAR_TYP = 1 → parity bit 0. For 0xA5, even → 0 and odd → 1.
- Ignore while busy: during a 0x3C frame, pulse Data_Valid with P_DATA = 0xFF and toggle PAR_EN/PAR_TYP → the 0x3C frame is unchanged and no second frame follows.
- Back-to-back: hold Data_Valid high with P_DATA = 0x55, then 0xAA → two complete frames separated by exactly one high idle cycle. A loopback into the UART RX chain recovers 0x55 then 0xAA with Parity_Error low in parity mode.
- Mid-frame reset: assert RST for 1 cycle during data bit 3 of 0x0F → TX_OUT = 1 and Busy = 0 on the next edge. A fresh 0x81 frame afterwards is bit-exact.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
//   Parallel-side handshake plus serial output of the UART transmit frame.
//   master : producer of bytes (drives P_DATA/Data_Valid/PAR_EN/PAR_TYP,
//            observes TX_OUT/Busy)
//   slave  : the transmitter (uart_tx_frame)
//   P_DATA     byte to transmit, sampled on accept
//   Data_Valid send request, honoured only while idle
//   PAR_EN     1 = append a parity bit
//   PAR_TYP    0 = even, 1 = odd parity
//   TX_OUT     serial line, idles high
//   Busy       high while a frame is in flight
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Shifts one asynchronous frame out on TX_OUT, LSB first:
//   start(0), DATA_WIDTH data bits, optional parity, stop(1).
//   Each serial bit lasts PRESCALE clock cycles, timed by an internal counter.
//   Ports:
//     CLK  system clock, rising edge
//     RST  synchronous active-high reset (aborts a frame in flight)
//     bus  uart_tx_frame_if slave modport (P_DATA, Data_Valid, PAR_EN,
//          PAR_TYP in; TX_OUT, Busy out, both registered)
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_frame_if.slave    bus
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

    assign bit_end = (cnt_q == CNT_LAST);

    // Outputs are computed for the state being entered, so TX_OUT and Busy
    // change on the same edge as the state register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_out_d  = tx_out_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
                if (bus.Data_Valid) begin
                    shift_d   = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = calc_parity(bus.P_DATA, bus.PAR_TYP);
                    bit_cnt_d = '0;
                    state_d   = START;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_out_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_out_d  = shift_d[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    tx_out_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Bench for uart_tx_frame (DATA_WIDTH = 8, PRESCALE = 8). A frame-level
//   model expands each accepted byte into its expected line waveform and a
//   compare process checks TX_OUT/Busy against it every cycle; directed
//   tests add hand-computed bit sequences and busy lengths.
module tb_uart_tx_frame;
    localparam int P  = 8;
    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;
    bit   model_on = 1'b0;
    logic line_q[$];

    task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        logic bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < DW; k++) bits.push_back(d[k]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < P; c++) line_q.push_back(bits[b]);
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            line_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            model_on = 1'b1;
        end else if (line_q.size() > 0) begin
            exp_tx   = line_q.pop_front();
            exp_busy = 1'b1;
        end else if (exp_busy) begin
            exp_tx   = 1'b1;   // mandatory idle cycle after stop
            exp_busy = 1'b0;
        end else if (bus.Data_Valid) begin
            build_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
            exp_tx   = line_q.pop_front();
            exp_busy = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (model_on) begin
            check("tx_line", 32'(bus.TX_OUT), 32'(exp_tx));
            check("busy",    32'(bus.Busy),   32'(exp_busy));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [10:0] exp_seq,
                             input int exp_busy_n, input bit disturb);
        logic [10:0] seen;
        int          busy_n;
        int          nb;
        nb     = pe ? 11 : 10;
        seen   = '0;
        busy_n = 0;
        @(negedge CLK);
        bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        check({name, "_first"}, {30'b0, bus.TX_OUT, bus.Busy}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge CLK);
            if (bus.Busy) busy_n++;
            if ((i % P) == P / 2 && (i / P) < nb) seen[i / P] = bus.TX_OUT;
            if (disturb && i == 20) begin
                bus.Data_Valid = 1'b1; bus.P_DATA = 8'hFF;
                bus.PAR_EN = ~pe; bus.PAR_TYP = ~pt;
            end
            if (disturb && i == 23) begin
                bus.Data_Valid = 1'b0; bus.P_DATA = d;
                bus.PAR_EN = pe; bus.PAR_TYP = pt;
            end
        end
        check({name, "_seq"}, 32'(seen), 32'(exp_seq));
        check({name, "_busy_len"}, busy_n, exp_busy_n);
    endtask

    logic rec_tx[200];
    logic rec_busy[200];

    // Loopback receiver: samples mid-bit from the frame starting at index s.
    function automatic logic [8:0] decode(input int s, input logic pt);
        logic [7:0] d;
        logic       par;
        for (int k = 0; k < 8; k++) d[k] = rec_tx[s + (k + 1) * P + P / 2];
        par = rec_tx[s + 9 * P + P / 2];
        return {((^d) ^ pt) != par, d};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a pending request
        bus.Data_Valid = 1'b1; bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_tx",   32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy),   32'd0);
        RST = 1'b0; bus.Data_Valid = 1'b0;
        @(negedge CLK);
        check("post_rst_idle", {30'b0, bus.TX_OUT, bus.Busy}, 32'd2);
        repeat (3) @(negedge CLK);

        run_frame("a5_nopar",   8'hA5, 1'b0, 1'b0, 11'b00_1101001010, 80, 1'b0);
        run_frame("07_even",    8'h07, 1'b1, 1'b0, 11'b11000001110,  88, 1'b0);
        run_frame("07_odd",     8'h07, 1'b1, 1'b1, 11'b10000001110,  88, 1'b0);
        run_frame("a5_even",    8'hA5, 1'b1, 1'b0, 11'b10101001010,  88, 1'b0);
        run_frame("a5_odd",     8'hA5, 1'b1, 1'b1, 11'b11101001010,  88, 1'b0);
        run_frame("3c_ignore",  8'h3C, 1'b0, 1'b0, 11'b00_1001111000, 80, 1'b1);

        // Back-to-back with Data_Valid held high, even parity
        @(negedge CLK);
        bus.P_DATA = 8'h55; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            rec_tx[i] = bus.TX_OUT; rec_busy[i] = bus.Busy;
            if (i == 0) bus.P_DATA = 8'hAA;
            if (i == 100) bus.Data_Valid = 1'b0;
        end
        check("b2b_last_stop", {30'b0, rec_tx[87], rec_busy[87]}, 32'd3);
        check("b2b_gap",       {30'b0, rec_tx[88], rec_busy[88]}, 32'd2);
        check("b2b_start2",    {30'b0, rec_tx[89], rec_busy[89]}, 32'd1);
        check("b2b_end2",      {30'b0, rec_tx[177], rec_busy[177]}, 32'd2);
        check("b2b_rx1", 32'(decode(0, 1'b0)),  32'h055);
        check("b2b_rx2", 32'(decode(89, 1'b0)), 32'h0AA);

        // Mid-frame reset during data bit 3 of 0x0F
        @(negedge CLK);
        bus.P_DATA = 8'h0F; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        for (int i = 1; i <= 35; i++) @(negedge CLK);
        check("mid_bit3", {30'b0, bus.TX_OUT, bus.Busy}, 32'd3);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_idle", {30'b0, bus.TX_OUT, bus.Busy}, 32'd2);
        RST = 1'b0;
        begin
            int busy_seen;
            busy_seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                if (bus.Busy || !bus.TX_OUT) busy_seen++;
            end
            check("mid_no_tail", busy_seen, 0);
        end
        run_frame("81_after_rst", 8'h81, 1'b0, 1'b0, 11'b00_1100000010, 80, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
